// File: rtl/sumador_restador_serial_if.sv
// sumador_restador_serial_if: start/operand inputs and status/result outputs of the serial adder-subtractor
interface sumador_restador_serial_if #(
    parameter int ANCHO = 4
);
    logic             inicio;
    logic             op;
    logic             acum;
    logic [ANCHO-1:0] a_in;
    logic [ANCHO-1:0] b_in;
    logic             ocupado;
    logic             listo;
    logic [ANCHO:0]   resultado;
    logic             desborde;
    modport master (
        output inicio, op, acum, a_in, b_in,
        input  ocupado, listo, resultado, desborde
    );
    modport slave (
        input  inicio, op, acum, a_in, b_in,
        output ocupado, listo, resultado, desborde
    );
endinterface

// File: rtl/sumador_restador_serial.sv
// sumador_restador_serial: bit-serial add/subtract, LSB first, one bit per clock, with carry/borrow and signed overflow
module sumador_restador_serial #(
    parameter int ANCHO = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    sumador_restador_serial_if.slave bus
);
    localparam int CW = $clog2(ANCHO);
    typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_t;
    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] a_q, a_d, b_q, b_d;
    logic             op_q, op_d, carry_q, carry_d;
    logic [ANCHO:0]   res_q, res_d;
    logic             desb_q, desb_d;
    logic             bb, s, cout, ultimo;
    // a_q shifts right and collects the sum bits in its top, so after ANCHO steps it holds the sum
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        res_d    = res_q;
        desb_d   = desb_q;
        bb       = b_q[0] ^ op_q;
        s        = a_q[0] ^ bb ^ carry_q;
        cout     = (a_q[0] & bb) | (carry_q & (a_q[0] ^ bb));
        ultimo   = cnt_q == CW'(ANCHO - 1);
        unique case (estado_q)
            REPOSO: if (bus.inicio) begin
                estado_d = CALCULO;
                op_d     = bus.op;
                b_d      = bus.b_in;
                a_d      = bus.acum ? res_q[ANCHO-1:0] : bus.a_in;
                cnt_d    = '0;
                carry_d  = bus.op;
            end
            CALCULO: begin
                a_d     = {s, a_q[ANCHO-1:1]};
                b_d     = b_q >> 1;
                carry_d = cout;
                cnt_d   = cnt_q + 1'b1;
                if (ultimo) begin
                    estado_d = FIN;
                    res_d    = {op_q ? ~cout : cout, s, a_q[ANCHO-1:1]};
                    desb_d   = carry_q ^ cout;
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            desb_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            desb_q   <= desb_d;
        end
    end
    assign bus.ocupado   = estado_q != REPOSO;
    assign bus.listo     = estado_q == FIN;
    assign bus.resultado = res_q;
    assign bus.desborde  = desb_q;
endmodule

// File: tb/tb_sumador_restador_serial.sv
// tb_sumador_restador_serial: scoreboard bench for the serial adder-subtractor at ANCHO=4
module tb_sumador_restador_serial;
    localparam int W = 4;
    typedef struct packed {
        logic [W:0] res;
        logic       ovf;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         errors = 0;
    int         checks = 0;
    exp_t       q[$];
    logic [W-1:0] acc = '0;
    sumador_restador_serial_if #(.ANCHO(W)) bus ();
    sumador_restador_serial #(.ANCHO(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        int   sa, sb, s;
        exp_t e;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        s     = o ? sa - sb : sa + sb;
        e.res = o ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        e.ovf = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        return e;
    endfunction
    task automatic start_op(input logic o, input logic ac, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] aa;
        for (int i = 0; i < 4 * W && bus.ocupado; i++) begin
            @(posedge clk);
            #1;
        end
        aa = ac ? acc : a;
        e  = model(o, aa, b);
        q.push_back(e);
        acc = e.res[W-1:0];
        bus.op = o; bus.acum = ac; bus.a_in = a; bus.b_in = b; bus.inicio = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        bus.op     = 1'($urandom);
        bus.acum   = 1'($urandom);
        bus.a_in   = W'($urandom);
        bus.b_in   = W'($urandom);
    endtask
    task automatic wait_listo(output int n, output int busy);
        n = 0;
        busy = 0;
        while (!bus.listo && n < 4 * W) begin
            if (bus.ocupado) busy++;
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.ocupado) busy++;
    endtask
    task automatic test_reset;
        bus.inicio = 1'b0; bus.op = 1'b0; bus.acum = 1'b0; bus.a_in = '0; bus.b_in = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.ocupado, bus.listo, bus.resultado, bus.desborde} !== '0) begin
            errors++;
            $display("FAIL reset_state ocupado=%b listo=%b resultado=%b desborde=%b required all 0",
                     bus.ocupado, bus.listo, bus.resultado, bus.desborde);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic test_add;
        int n, busy;
        exp_t e;
        start_op(1'b0, 1'b0, 4'd7, 4'd1);
        wait_listo(n, busy);
        checks++;
        if (n + 1 !== W + 1) begin
            errors++;
            $display("FAIL add_latency edges=%0d required %0d", n + 1, W + 1);
        end
        checks++;
        if (busy !== W + 1) begin
            errors++;
            $display("FAIL add_ocupado cycles=%0d required %0d", busy, W + 1);
        end
        e = q.pop_front();
        checks++;
        if (bus.resultado !== e.res || bus.desborde !== e.ovf || e.res !== 5'b01000) begin
            errors++;
            $display("FAIL add_7_1 resultado=%b desborde=%b required 01000 1", bus.resultado, bus.desborde);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL add_listo_pulse listo=%b ocupado=%b required 0 0", bus.listo, bus.ocupado);
        end
        checks++;
        if (bus.resultado !== 5'b01000 || bus.desborde !== 1'b1) begin
            errors++;
            $display("FAIL add_hold resultado=%b desborde=%b required 01000 1", bus.resultado, bus.desborde);
        end
    endtask
    task automatic test_sub;
        int n, busy;
        exp_t e;
        start_op(1'b1, 1'b0, 4'd3, 4'd5);
        wait_listo(n, busy);
        e = q.pop_front();
        checks++;
        if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf) begin
            errors++;
            $display("FAIL sub_3_5 resultado=%b desborde=%b required %b %b", bus.resultado, bus.desborde, e.res, e.ovf);
        end
        start_op(1'b1, 1'b0, 4'd8, 4'd1);
        wait_listo(n, busy);
        e = q.pop_front();
        checks++;
        if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf) begin
            errors++;
            $display("FAIL sub_8_1 resultado=%b desborde=%b required %b %b", bus.resultado, bus.desborde, e.res, e.ovf);
        end
    endtask
    task automatic test_acum;
        int n, busy;
        exp_t e;
        start_op(1'b0, 1'b0, 4'd3, 4'd4);
        wait_listo(n, busy);
        e = q.pop_front();
        checks++;
        if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf) begin
            errors++;
            $display("FAIL acum_first resultado=%b desborde=%b required %b %b", bus.resultado, bus.desborde, e.res, e.ovf);
        end
        start_op(1'b0, 1'b1, 4'd15, 4'd2);
        wait_listo(n, busy);
        e = q.pop_front();
        checks++;
        if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf || e.res !== 5'b01001) begin
            errors++;
            $display("FAIL acum_chain resultado=%b desborde=%b required 01001 1", bus.resultado, bus.desborde);
        end
    endtask
    task automatic test_ignore;
        int   nl;
        exp_t e;
        nl = 0;
        start_op(1'b0, 1'b0, 4'd5, 4'd2);
        e = q.pop_front();
        for (int k = 1; k <= W + 1; k++) begin
            bus.inicio = (k == 2 || k == W + 1);
            bus.a_in   = W'($urandom);
            if (bus.listo) begin
                nl++;
                checks++;
                if (bus.resultado !== e.res || bus.desborde !== e.ovf) begin
                    errors++;
                    $display("FAIL ignore_result resultado=%b desborde=%b required %b %b",
                             bus.resultado, bus.desborde, e.res, e.ovf);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.inicio = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            if (bus.listo || bus.ocupado) nl += 10;
            @(posedge clk);
            #1;
        end
        checks++;
        if (nl !== 1) begin
            errors++;
            $display("FAIL ignore_single_op activity=%0d required 1", nl);
        end
    endtask
    task automatic test_reset_mid;
        int   n, busy, nl;
        exp_t e;
        start_op(1'b0, 1'b0, 4'd1, 4'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ocupado, bus.listo, bus.resultado, bus.desborde} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async ocupado=%b listo=%b resultado=%b desborde=%b required all 0",
                     bus.ocupado, bus.listo, bus.resultado, bus.desborde);
        end
        void'(q.pop_back());
        acc = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nl = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk);
            #1;
            if (bus.listo || bus.ocupado) nl++;
        end
        checks++;
        if (nl !== 0) begin
            errors++;
            $display("FAIL reset_mid_abort activity=%0d required 0", nl);
        end
        start_op(1'b0, 1'b1, 4'd9, 4'd3);
        wait_listo(n, busy);
        e = q.pop_front();
        checks++;
        if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf || e.res !== 5'b00011) begin
            errors++;
            $display("FAIL acum_after_reset resultado=%b desborde=%b required 00011 0", bus.resultado, bus.desborde);
        end
        start_op(1'b0, 1'b0, 4'd15, 4'd15);
        wait_listo(n, busy);
        e = q.pop_front();
        checks++;
        if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf || e.res !== 5'b11110) begin
            errors++;
            $display("FAIL fresh_15_15 resultado=%b desborde=%b required 11110 0", bus.resultado, bus.desborde);
        end
    endtask
    task automatic test_back_to_back;
        int   n, busy;
        exp_t e;
        for (int o = 0; o < 2; o++)
            for (int a = 0; a < (1 << W); a++)
                for (int b = 0; b < (1 << W); b++) begin
                    start_op(1'(o), 1'b0, W'(a), W'(b));
                    wait_listo(n, busy);
                    e = q.pop_front();
                    checks++;
                    if (bus.listo !== 1'b1 || bus.resultado !== e.res || bus.desborde !== e.ovf) begin
                        errors++;
                        $display("FAIL sweep op=%0d a=%0d b=%0d resultado=%b desborde=%b required %b %b",
                                 o, a, b, bus.resultado, bus.desborde, e.res, e.ovf);
                    end
                end
    endtask
    initial begin
        test_reset;
        test_add;
        test_sub;
        test_acum;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sumador_restador_serial.md
SUMADOR_RESTADOR_SERIAL -- requirements
Module: sumador_restador_serial

Interface
REQ-001 The block SHALL have parameter ANCHO, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port inicio, input, 1 bit: start request, sampled on rising clk edges.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = add, 1 = subtract; sampled with inicio.
REQ-006 The block SHALL have port acum, input, 1 bit: 1 = use the previous result in place of a_in; sampled with inicio.
REQ-007 The block SHALL have port a_in, input, ANCHO bits: first operand (minuend).
REQ-008 The block SHALL have port b_in, input, ANCHO bits: second operand (subtrahend).
REQ-009 The block SHALL have port ocupado, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port listo, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port resultado, output, ANCHO+1 bits: the result, with the carry/borrow in the MSB.
REQ-012 The block SHALL have port desborde, output, 1 bit: signed (two's-complement) overflow of the ANCHO-bit result.

Function
REQ-013 The FSM SHALL have exactly three states: REPOSO, CALCULO and FIN.
REQ-014 In REPOSO, inicio=1 at a rising edge SHALL do all of the following:
- latch op, b_in and operand A (A = resultado[ANCHO-1:0] if acum=1, else a_in);
- clear the bit counter;
- set the internal carry to op;
- move to CALCULO.
REQ-015 In CALCULO, each cycle SHALL process one bit, LSB first:
- sum bit = A[i] XOR (B[i] XOR op) XOR carry;
- carry updated by the full-adder rule;
- counter incremented.
REQ-016 When the bit at index ANCHO-1 is processed, the FSM SHALL go to FIN; CALCULO SHALL last exactly ANCHO cycles.
REQ-017 FIN SHALL last exactly one cycle and SHALL return to REPOSO unconditionally.
REQ-018 On entry to FIN, resultado SHALL be updated as follows:
- bits [ANCHO-1:0] = sum bits;
- for add, bit ANCHO = final carry;
- for subtract, bit ANCHO = NOT final carry (the borrow);
- so resultado always equals the exact (ANCHO+1)-bit two's-complement value of A+B or A-B.
REQ-019 desborde SHALL be updated in FIN as (carry into MSB) XOR (carry out of MSB).
REQ-020 resultado and desborde SHALL hold their values until the next entry to FIN or reset, and SHALL never show intermediate bits.
REQ-021 ocupado SHALL be 1 in CALCULO and FIN and 0 in REPOSO.
REQ-022 listo SHALL be 1 only in FIN.
REQ-023 Latency: listo SHALL go high ANCHO+1 rising edges after the edge that sampled inicio.
REQ-024 inicio SHALL be ignored while ocupado=1; no queuing, and in-flight operands are unaffected.
REQ-025 Changes on a_in, b_in, op and acum after the start edge SHALL NOT affect the operation in progress.
REQ-026 The earliest back-to-back start SHALL be the first REPOSO cycle after FIN, giving a throughput of one operation per ANCHO+2 cycles.
REQ-027 acum=1 as the first operation after reset SHALL use A = 0.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force:
- state REPOSO;
- ocupado=0, listo=0, resultado=0, desborde=0;
- internal counter, carry and operand registers to 0.
REQ-029 Reset asserted mid-CALCULO SHALL abort the operation with no listo pulse; the pre-reset result is lost.
REQ-030 After rst_n deasserts, the first rising edge with inicio=1 SHALL start a new operation normally.

Verification (ANCHO=4)
REQ-031 Scenario: op=0, a=7, b=1 -> listo after 5 edges; resultado=5'b01000, desborde=1; ocupado high for 5 cycles.
REQ-032 Scenario: op=1, a=3, b=5 -> resultado=5'b11110 (-2), desborde=0; then op=1, a=8, b=1 -> resultado=5'b00111, desborde=1.
REQ-033 Scenario: op=0, a=3, b=4 (result 7), then acum=1, op=0, b=2, a_in=15 -> resultado=5'b01001, desborde=1 (a_in ignored).
REQ-034 Scenario: inicio pulsed again in cycles 2 and 5 of an operation with a changing a_in -> single listo, original operands' result, no second operation.
REQ-035 Scenario: rst_n low in the third CALCULO cycle -> all outputs 0 at once, no listo; a fresh 15+15 afterwards -> resultado=5'b11110, desborde=0.
REQ-036 Scenario: exhaustive sweep of all 512 combinations of op, a and b, back-to-back starts -> every resultado equals the 5-bit value of a±b, and desborde equals the signed-overflow reference.
